// File: rtl/titan_def_pkg.sv
// Shared definitions for the Titan EX stage: ALU opcodes, memory-flag and
// exception bit positions, the NOP encoding and the EX/MEM register layout.
package titan_def;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_A = 4'd10;
  localparam logic [3:0] ALU_PASS_B = 4'd11;
  localparam logic [3:0] ALU_ADD4   = 4'd12;

  localparam int MF_READ     = 0;
  localparam int MF_WRITE    = 1;
  localparam int MF_SIZE_LO  = 2;
  localparam int MF_SIZE_HI  = 3;
  localparam int MF_UNSIGNED = 4;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int EXC_ILLEGAL        = 0;
  localparam int EXC_ADDR_MISALIGN  = 1;
  localparam int EXC_ACCESS_FAULT   = 2;
  localparam int EXC_FENCE          = 3;
  localparam int EXC_XRET           = 4;
  localparam int EXC_BREAK          = 5;
  localparam int EXC_SYSCALL        = 6;
  localparam int EXC_LOAD_MISALIGN  = 7;
  localparam int EXC_STORE_MISALIGN = 8;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  waddr;
    logic        we;
    logic [5:0]  mem_flags;
    logic        mem_ex_sel;
    logic [8:0]  exc;
    logic [31:0] csr_data;
    logic [2:0]  csr_op;
    logic [11:0] csr_addr;
  } ex_mem_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SIZE_HALF) && addr_lo[0]) || ((size == SIZE_WORD) && (addr_lo != 2'b00));
  endfunction

  function automatic ex_mem_t bubble();
    ex_mem_t b;
    b = '0;
    b.instruction = NOP_INSTR;
    return b;
  endfunction

endpackage

// File: rtl/titan_alu.sv
// Combinational 32-bit ALU for the EX stage; undefined opcodes yield zero.
module titan_alu
  import titan_def::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  op_i,
  output logic [31:0] result_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:    result_o = a_i + b_i;
      ALU_SUB:    result_o = a_i - b_i;
      ALU_SLL:    result_o = a_i << shamt;
      ALU_SLT:    result_o = {31'd0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU:   result_o = {31'd0, a_i < b_i};
      ALU_XOR:    result_o = a_i ^ b_i;
      ALU_SRL:    result_o = a_i >> shamt;
      ALU_SRA:    result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_OR:     result_o = a_i | b_i;
      ALU_AND:    result_o = a_i & b_i;
      ALU_PASS_A: result_o = a_i;
      ALU_PASS_B: result_o = b_i;
      ALU_ADD4:   result_o = a_i + 32'd4;
      default:    result_o = '0;
    endcase
  end

endmodule

// File: rtl/titan_ex_stage.sv
// Titan execute stage: ALU, data-address misalignment detection and the
// EX/MEM pipeline register with flush/stall control.
module titan_ex_stage
  import titan_def::*;
#(
  parameter int MISALIGN_CHECK = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_stall_i,
  input  logic        ex_flush_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_instruction_i,
  input  logic [31:0] ex_port_a_i,
  input  logic [31:0] ex_port_b_i,
  input  logic [3:0]  ex_alu_op_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic        ex_we_i,
  input  logic [31:0] ex_store_data_i,
  input  logic [5:0]  ex_mem_flags_i,
  input  logic        ex_mem_ex_sel_i,
  input  logic [6:0]  ex_exc_i,
  input  logic [31:0] ex_csr_data_i,
  input  logic [2:0]  ex_csr_op_i,
  input  logic [11:0] ex_csr_addr_i,
  output logic [31:0] ex_fwd_drd_o,
  output logic [31:0] mem_pc_o,
  output logic [31:0] mem_instruction_o,
  output logic [31:0] mem_alu_result_o,
  output logic [31:0] mem_store_data_o,
  output logic [4:0]  mem_waddr_o,
  output logic        mem_we_o,
  output logic [5:0]  mem_mem_flags_o,
  output logic        mem_mem_ex_sel_o,
  output logic [8:0]  mem_exc_o,
  output logic [31:0] mem_csr_data_o,
  output logic [2:0]  mem_csr_op_o,
  output logic [11:0] mem_csr_addr_o
);

  logic [31:0] alu_result;
  logic        ld_mis;
  logic        st_mis;
  logic [8:0]  exc_all;
  logic        any_exc;
  ex_mem_t     ex_mem_d;
  ex_mem_t     ex_mem_q;

  titan_alu u_alu (
    .a_i      (ex_port_a_i),
    .b_i      (ex_port_b_i),
    .op_i     (ex_alu_op_i),
    .result_o (alu_result)
  );

  assign ex_fwd_drd_o = alu_result;

  generate
    if (MISALIGN_CHECK != 0) begin : g_misalign
      logic size_mis;
      assign size_mis = is_misaligned(ex_mem_flags_i[MF_SIZE_HI:MF_SIZE_LO], alu_result[1:0]);
      assign ld_mis   = ex_mem_flags_i[MF_READ]  && size_mis;
      assign st_mis   = ex_mem_flags_i[MF_WRITE] && size_mis;
    end else begin : g_no_misalign
      assign ld_mis = 1'b0;
      assign st_mis = 1'b0;
    end
  endgenerate

  assign exc_all = {st_mis, ld_mis, ex_exc_i};
  assign any_exc = |exc_all;

  // A faulting instruction must not commit a register write or touch memory.
  always_comb begin
    ex_mem_d             = '0;
    ex_mem_d.pc          = ex_pc_i;
    ex_mem_d.instruction = ex_instruction_i;
    ex_mem_d.alu_result  = alu_result;
    ex_mem_d.store_data  = ex_store_data_i;
    ex_mem_d.waddr       = ex_waddr_i;
    ex_mem_d.we          = ex_we_i && !any_exc;
    ex_mem_d.mem_flags   = {ex_mem_flags_i[5:2], any_exc ? 2'b00 : ex_mem_flags_i[1:0]};
    ex_mem_d.mem_ex_sel  = ex_mem_ex_sel_i;
    ex_mem_d.exc         = exc_all;
    ex_mem_d.csr_data    = ex_csr_data_i;
    ex_mem_d.csr_op      = ex_csr_op_i;
    ex_mem_d.csr_addr    = ex_csr_addr_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || ex_flush_i) begin
      ex_mem_q <= bubble();
    end else if (!ex_stall_i) begin
      ex_mem_q <= ex_mem_d;
    end
  end

  assign mem_pc_o          = ex_mem_q.pc;
  assign mem_instruction_o = ex_mem_q.instruction;
  assign mem_alu_result_o  = ex_mem_q.alu_result;
  assign mem_store_data_o  = ex_mem_q.store_data;
  assign mem_waddr_o       = ex_mem_q.waddr;
  assign mem_we_o          = ex_mem_q.we;
  assign mem_mem_flags_o   = ex_mem_q.mem_flags;
  assign mem_mem_ex_sel_o  = ex_mem_q.mem_ex_sel;
  assign mem_exc_o         = ex_mem_q.exc;
  assign mem_csr_data_o    = ex_mem_q.csr_data;
  assign mem_csr_op_o      = ex_mem_q.csr_op;
  assign mem_csr_addr_o    = ex_mem_q.csr_addr;

endmodule

// File: tb/tb_titan_ex_stage.sv
// Self-checking bench for titan_ex_stage: directed corner cases plus random
// traffic compared every cycle against a behavioural model.
module tb_titan_ex_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush;
  logic [31:0] pc, instr, a, b, sd, csrd;
  logic [3:0]  op;
  logic [4:0]  waddr;
  logic        we, msel;
  logic [5:0]  mflags;
  logic [6:0]  exc;
  logic [2:0]  csrop;
  logic [11:0] csra;

  logic [31:0] fwd, o_pc, o_instr, o_alu, o_sd, o_csrd;
  logic [4:0]  o_waddr;
  logic        o_we, o_sel;
  logic [5:0]  o_flags;
  logic [8:0]  o_exc;
  logic [2:0]  o_csrop;
  logic [11:0] o_csra;

  titan_ex_stage #(.MISALIGN_CHECK(1)) dut (
    .clk_i(clk), .rst_i(rst), .ex_stall_i(stall), .ex_flush_i(flush),
    .ex_pc_i(pc), .ex_instruction_i(instr), .ex_port_a_i(a), .ex_port_b_i(b),
    .ex_alu_op_i(op), .ex_waddr_i(waddr), .ex_we_i(we), .ex_store_data_i(sd),
    .ex_mem_flags_i(mflags), .ex_mem_ex_sel_i(msel), .ex_exc_i(exc),
    .ex_csr_data_i(csrd), .ex_csr_op_i(csrop), .ex_csr_addr_i(csra),
    .ex_fwd_drd_o(fwd), .mem_pc_o(o_pc), .mem_instruction_o(o_instr),
    .mem_alu_result_o(o_alu), .mem_store_data_o(o_sd), .mem_waddr_o(o_waddr),
    .mem_we_o(o_we), .mem_mem_flags_o(o_flags), .mem_mem_ex_sel_o(o_sel),
    .mem_exc_o(o_exc), .mem_csr_data_o(o_csrd), .mem_csr_op_o(o_csrop),
    .mem_csr_addr_o(o_csra)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model of what the pipeline register must hold.
  logic [31:0] m_pc, m_instr, m_alu, m_sd, m_csrd;
  logic [4:0]  m_waddr;
  logic        m_we, m_sel;
  logic [5:0]  m_flags;
  logic [8:0]  m_exc;
  logic [2:0]  m_csrop;
  logic [11:0] m_csra;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] x, input logic [31:0] y, input logic [3:0] o);
    int unsigned sh;
    sh = y % 32;
    case (o)
      4'd0:  return x + y;
      4'd1:  return x - y;
      4'd2:  return x << sh;
      4'd3:  return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
      4'd4:  return (x < y) ? 32'd1 : 32'd0;
      4'd5:  return x ^ y;
      4'd6:  return x >> sh;
      4'd7:  return (x >> sh) | (x[31] ? ~(32'hFFFFFFFF >> sh) : 32'h0);
      4'd8:  return x | y;
      4'd9:  return x & y;
      4'd10: return x;
      4'd11: return y;
      4'd12: return x + 32'd4;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [31:0] r;
    logic        mis, lm, sm, fault;
    if (rst || flush) begin
      m_pc <= 0; m_instr <= 32'h13; m_alu <= 0; m_sd <= 0; m_csrd <= 0;
      m_waddr <= 0; m_we <= 0; m_sel <= 0; m_flags <= 0; m_exc <= 0;
      m_csrop <= 0; m_csra <= 0;
    end else if (!stall) begin
      r     = ref_alu(a, b, op);
      mis   = (mflags[3:2] == 2'd1 && (r % 2) != 0) || (mflags[3:2] == 2'd2 && (r % 4) != 0);
      lm    = mflags[0] && mis;
      sm    = mflags[1] && mis;
      fault = lm || sm || (exc != 0);
      m_pc <= pc; m_instr <= instr; m_alu <= r; m_sd <= sd; m_csrd <= csrd;
      m_waddr <= waddr; m_we <= we && !fault; m_sel <= msel;
      m_flags <= fault ? {mflags[5:2], 2'b00} : mflags;
      m_exc <= {sm, lm, exc}; m_csrop <= csrop; m_csra <= csra;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp("fwd", fwd, ref_alu(a, b, op));
      cmp("pc", o_pc, m_pc);
      cmp("instr", o_instr, m_instr);
      cmp("alu", o_alu, m_alu);
      cmp("store_data", o_sd, m_sd);
      cmp("waddr", {27'd0, o_waddr}, {27'd0, m_waddr});
      cmp("we", {31'd0, o_we}, {31'd0, m_we});
      cmp("flags", {26'd0, o_flags}, {26'd0, m_flags});
      cmp("ex_sel", {31'd0, o_sel}, {31'd0, m_sel});
      cmp("exc", {23'd0, o_exc}, {23'd0, m_exc});
      cmp("csr_data", o_csrd, m_csrd);
      cmp("csr_op", {29'd0, o_csrop}, {29'd0, m_csrop});
      cmp("csr_addr", {20'd0, o_csra}, {20'd0, m_csra});
    end
  end

  task automatic quiet_inputs();
    pc = 0; instr = 0; a = 0; b = 0; op = 0; waddr = 0; we = 0; sd = 0;
    mflags = 0; msel = 0; exc = 0; csrd = 0; csrop = 0; csra = 0;
  endtask

  task automatic rand_inputs();
    pc = $urandom; instr = $urandom; sd = $urandom; csrd = $urandom;
    a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom;
    b = $urandom; op = 4'($urandom_range(0, 15));
    waddr = 5'($urandom); we = 1'($urandom); msel = 1'($urandom);
    mflags = 6'($urandom);
    exc = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'd0;
    csrop = 3'($urandom); csra = 12'($urandom);
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0;
    quiet_inputs();
    next_edge();
    next_edge();
    cmp_en = 1'b1;
    cmp("reset_instr", o_instr, 32'h00000013);
    cmp("reset_pc", o_pc, 32'h0);
    rst = 0;

    // Signed overflow wraps.
    a = 32'h7FFFFFFF; b = 32'd1; op = 4'd0;
    @(negedge clk);
    cmp("add_fwd", fwd, 32'h80000000);
    next_edge();
    cmp("add_reg", o_alu, 32'h80000000);
    $display("txn add overflow alu=%h", o_alu);

    // Shift amount uses only b[4:0].
    a = 32'h80000000; b = 32'd33; op = 4'd7;
    @(negedge clk);
    cmp("sra", fwd, 32'hC0000000);
    op = 4'd4; #1;
    cmp("sltu", fwd, 32'h0);
    a = 32'hFFFFFFFF; b = 32'd0; op = 4'd3; #1;
    cmp("slt", fwd, 32'h1);
    next_edge();
    $display("txn shift/compare alu=%h", o_alu);

    // Misaligned word store.
    a = 32'h1002; op = 4'd10; mflags = 6'b001010; we = 0;
    next_edge();
    cmp("st_mis_bit", {31'd0, o_exc[8]}, 32'd1);
    cmp("st_mis_flags", {26'd0, o_flags}, 32'h08);
    $display("txn misaligned store exc=%h", o_exc);

    // Illegal instruction suppresses the write but keeps waddr.
    mflags = 0; a = 32'h100; op = 4'd0; exc = 7'd1; we = 1; waddr = 5'd5;
    next_edge();
    cmp("illegal_we", {31'd0, o_we}, 32'd0);
    cmp("illegal_exc", {31'd0, o_exc[0]}, 32'd1);
    cmp("illegal_waddr", {27'd0, o_waddr}, 32'd5);
    $display("txn illegal we=%b waddr=%0d", o_we, o_waddr);
    exc = 0;

    // Stall holds for three cycles while inputs move.
    pc = 32'hAAAA0000; instr = 32'h12345678;
    next_edge();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      next_edge();
      cmp("stall_pc", o_pc, 32'hAAAA0000);
      cmp("stall_instr", o_instr, 32'h12345678);
    end
    flush = 1;
    next_edge();
    cmp("flush_instr", o_instr, 32'h00000013);
    cmp("flush_pc", o_pc, 32'h0);
    $display("txn stall+flush instr=%h", o_instr);
    flush = 0; stall = 0;

    // Reset in the middle of a stall discards held contents.
    quiet_inputs(); pc = 32'hBBBB0000; instr = 32'h11111111;
    next_edge();
    stall = 1; rst = 1;
    next_edge();
    cmp("rst_stall_pc", o_pc, 32'h0);
    cmp("rst_stall_instr", o_instr, 32'h00000013);
    rst = 0; stall = 0; pc = 32'hCCCC0000;
    next_edge();
    cmp("post_rst_pc", o_pc, 32'hCCCC0000);
    $display("txn reset during stall pc=%h", o_pc);

    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 49) == 0);
      next_edge();
    end
    rst = 0; stall = 0; flush = 0;
    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
